pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register, successor to the fixed IF/ID stage register. Replaces the stall/clear pair with a valid/ready handshake and a two-entry skid buffer, so stall back-pressure is registered and never combinationally chained across stages. Flush masks selected bit fields to zero: for example, the instruction field is cleared while the PC+4 field passes through. It also keeps a saturating stall-cycle counter for performance monitoring. Instantiated between any two core pipeline stages.

---
 rtl/pipe_stage_skid.sv | 84 ++++++++
 tb/tb_pipe_stage_skid.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Flush masks selected payload fields to zero; a saturating counter tracks stall cycles.
module pipe_stage_skid #(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  FLUSH_MASK = {32'hFFFF_FFFF, 32'h0},
  parameter logic [DATA_W-1:0]  RESET_VAL  = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid;
  logic              acc, dlv;

  // Handshakes use only registered readiness, so out_ready never reaches in_ready.
  assign acc       = in_valid & in_ready;
  assign dlv       = out_valid & out_ready;
  assign occupancy = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= RESET_VAL;
      skid      <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        // Bubble still carries the unmasked fields (e.g. PC+4).
        state     <= EMPTY;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
        out_data  <= in_data & ~FLUSH_MASK;
      end else begin
        case (state)
          EMPTY: if (acc) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
          ONE: begin
            if (acc && dlv) begin
              out_data <= in_data;
            end else if (acc) begin
              state    <= TWO;
              in_ready <= 1'b0;
              skid     <= in_data;
            end else if (dlv) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          TWO: if (dlv) begin
            state    <= ONE;
            in_ready <= 1'b1;
            out_data <= skid;
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: FIFO-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_skid;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;
  localparam logic [DATA_W-1:0] MASK = {32'hFFFF_FFFF, 32'h0};

  logic              CLK = 1'b0, RST = 1'b0;
  logic              flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  int pass = 0, total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a 2-deep FIFO plus the last value shown when empty.
  logic [1:0]        mcnt;
  logic [DATA_W-1:0] mq0, mq1, mlast;
  logic [CNT_W-1:0]  mstall;
  logic [DATA_W-1:0] mdata;
  assign mdata = (mcnt != 0) ? mq0 : mlast;

  always @(posedge CLK or negedge RST) begin : model
    int n;
    logic [DATA_W-1:0] q0, q1, last;
    if (!RST) begin
      mcnt <= 0; mq0 <= '0; mq1 <= '0; mlast <= '0; mstall <= '0;
    end else begin
      n = mcnt; q0 = mq0; q1 = mq1; last = mdata;
      if (mcnt != 0 && !out_ready && mstall != {CNT_W{1'b1}}) mstall <= mstall + 1'b1;
      if (flush) begin
        n = 0; last = in_data & ~MASK;
      end else begin
        if (out_ready && mcnt != 0) begin last = q0; q0 = q1; n--; end
        if (in_valid && mcnt != 2) begin
          if (n == 0) q0 = in_data; else q1 = in_data;
          n++;
        end
      end
      mcnt <= n[1:0]; mq0 <= q0; mq1 <= q1; mlast <= last;
    end
  end

  always @(negedge CLK)
    check("model", {out_valid, in_ready, occupancy, stall_cnt, out_data},
          {mcnt != 0, mcnt != 2, mcnt, mstall, mdata});

  // Delivered-beat log for the in-order checks.
  logic [DATA_W-1:0] dlog [0:255];
  int dcnt = 0;
  always @(posedge CLK)
    if (RST && out_valid && out_ready) begin
      dlog[dcnt[7:0]] <= out_data;
      dcnt <= dcnt + 1;
    end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  initial begin
    int base;
    logic r;
    repeat (2) step();
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_data",  out_data, 0);
    check("rst_occ",   occupancy, 0);
    check("rst_stall", stall_cnt, 0);
    RST = 1'b1;

    // Full-throughput stream.
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 64'h11 + 64'(i);
      step();
      check("stream_data", out_data, 64'h11 + 64'(i));
      check("stream_ready", in_ready, 1);
    end
    in_valid = 0;
    step();
    check("stream_stall", stall_cnt, 0);
    check("stream_empty", out_valid, 0);

    // Back-pressure fills the skid, then drains in order.
    base = dcnt;
    out_ready = 0; in_valid = 1; in_data = 64'hA1;
    step(); check("bp_occ1", occupancy, 1);
    in_data = 64'hA2;
    step(); check("bp_occ2", occupancy, 2); check("bp_ready", in_ready, 0);
    in_data = 64'hA3;
    step(); step();
    check("bp_stall3", stall_cnt, 3);
    out_ready = 1;
    step(); step();
    in_valid = 0;
    step(); step();
    check("bp_ord0", dlog[base[7:0]], 64'hA1);
    check("bp_ord1", dlog[8'(base + 1)], 64'hA2);
    check("bp_ord2", dlog[8'(base + 2)], 64'hA3);
    check("bp_stall_end", stall_cnt, 3);

    // Flush from TWO.
    out_ready = 0; in_valid = 1; in_data = 64'hB1;
    step(); in_data = 64'hB2;
    step(); check("fl_pre_occ", occupancy, 2);
    in_data = {32'h1234_5678, 32'h0000_0104}; flush = 1;
    step(); flush = 0; in_valid = 0;
    check("fl_valid", out_valid, 0);
    check("fl_data",  out_data, 64'h0000_0000_0000_0104);
    check("fl_occ",   occupancy, 0);
    check("fl_ready", in_ready, 1);
    check("fl_stall", stall_cnt, 5);

    // Saturation.
    in_valid = 1; in_data = 64'h77;
    step(); in_valid = 0;
    repeat (70000) step();
    check("sat_stall", stall_cnt, 16'hFFFF);
    out_ready = 1;
    step();

    // Asynchronous reset while in TWO.
    out_ready = 0; in_valid = 1; in_data = 64'hC1;
    step(); in_data = 64'hC2;
    step(); in_valid = 0;
    check("ar_pre_occ", occupancy, 2);
    @(posedge CLK); #3; RST = 0; #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 1);
    check("ar_data",  out_data, 0);
    check("ar_occ",   occupancy, 0);
    check("ar_stall", stall_cnt, 0);
    #2; RST = 1;
    in_valid = 1; in_data = 64'h55; out_ready = 1;
    step(); in_valid = 0;
    check("ar_d55", out_data, 64'h55);
    check("ar_v55", out_valid, 1);
    step();

    // Random handshakes; in_ready must not react to out_ready within a cycle.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      r = in_ready;
      out_ready = ~out_ready; #1;
      check("rnd_ready_indep", in_ready, r);
      out_ready = ~out_ready;
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) step();
    check("rnd_drained", occupancy, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
